// File: rtl/clock_div_monitor.sv
// Divided-clock monitor: measures each half-period of div_i in clk cycles, tracks lock and
// flags short/long/stuck intervals. Define DIV_MON_STICKY_EN to latch FAULT until clr_i.
module clock_div_monitor #(
  parameter int unsigned EXP_HALF = 1040,
  parameter int unsigned TOL      = 8,
  parameter int unsigned LOCK_N   = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             div_i,
  input  logic             clr_i,
  output logic             locked_o,
  output logic             fault_o,
  output logic [1:0]       fault_code_o,
  output logic [CNT_W-1:0] half_cnt_o,
  output logic             meas_vld_o
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StAcq    = 2'd1;
  localparam logic [1:0] StLocked = 2'd2;
  localparam logic [1:0] StFault  = 2'd3;

  localparam logic [1:0] CodeNone  = 2'b00;
  localparam logic [1:0] CodeShort = 2'b01;
  localparam logic [1:0] CodeLong  = 2'b10;
  localparam logic [1:0] CodeStuck = 2'b11;

  localparam logic [CNT_W-1:0] WinLo    = CNT_W'(EXP_HALF - TOL);
  localparam logic [CNT_W-1:0] WinHi    = CNT_W'(EXP_HALF + TOL);
  localparam logic [CNT_W-1:0] StuckCnt = CNT_W'(2 * EXP_HALF - 1);
  localparam logic [CNT_W-1:0] CntMax   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);
  localparam logic [3:0]       LockN    = 4'(LOCK_N);

  logic [2:0]       sync_q;
  logic             evt_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] half_q, half_d;
  logic             vld_q;
  logic [1:0]       state_q, state_d;
  logic [3:0]       good_q, good_d;
  logic [1:0]       code_q, code_d;

  logic             edge_det;
  logic [CNT_W-1:0] meas;
  logic             is_short, is_long, in_win, stuck;

  // sync_q[1:0] is the synchronizer; sync_q[2] is the edge-detect history flop.
  assign edge_det = sync_q[1] ^ sync_q[2];

  always_comb begin
    meas     = (cnt_q == CntMax) ? cnt_q : cnt_q + CntOne;
    is_short = meas < WinLo;
    is_long  = meas > WinHi;
    in_win   = !is_short && !is_long;
    stuck    = !evt_q && (cnt_q == StuckCnt);
  end

  always_comb begin
    cnt_d   = evt_q ? '0 : ((cnt_q == CntMax) ? cnt_q : cnt_q + CntOne);
    half_d  = evt_q ? meas : half_q;
    state_d = state_q;
    good_d  = good_q;
    code_d  = clr_i ? CodeNone : code_q;

    case (state_q)
      StIdle: begin
        if (evt_q) begin
          state_d = StAcq;
          good_d  = '0;
        end
      end
      StAcq: begin
        if (evt_q) begin
          if (in_win) begin
            good_d = good_q + 4'd1;
            if (good_q + 4'd1 == LockN) state_d = StLocked;
          end else begin
            good_d = '0;
          end
        end else if (stuck) begin
          state_d = StIdle;
          good_d  = '0;
        end
      end
      StLocked: begin
        // Fault detection takes priority over a simultaneous clr_i.
        if (evt_q && is_short) begin
          state_d = StFault;
          code_d  = CodeShort;
          good_d  = '0;
        end else if (evt_q && is_long) begin
          state_d = StFault;
          code_d  = CodeLong;
          good_d  = '0;
        end else if (stuck) begin
          state_d = StFault;
          code_d  = CodeStuck;
          good_d  = '0;
        end
      end
      StFault: begin
`ifdef DIV_MON_STICKY_EN
        if (clr_i) begin
          state_d = StIdle;
          good_d  = '0;
        end
`else
        if (evt_q) begin
          state_d = StAcq;
          good_d  = '0;
        end
`endif
      end
      default: begin
        state_d = StIdle;
        good_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q  <= '0;
      evt_q   <= 1'b0;
      cnt_q   <= '0;
      half_q  <= '0;
      vld_q   <= 1'b0;
      state_q <= StIdle;
      good_q  <= '0;
      code_q  <= CodeNone;
    end else begin
      sync_q  <= {sync_q[1:0], div_i};
      evt_q   <= edge_det;
      cnt_q   <= cnt_d;
      half_q  <= half_d;
      vld_q   <= evt_q;
      state_q <= state_d;
      good_q  <= good_d;
      code_q  <= code_d;
    end
  end

  assign locked_o     = (state_q == StLocked);
  assign fault_o      = (state_q == StFault);
  assign fault_code_o = code_q;
  assign half_cnt_o   = half_q;
  assign meas_vld_o   = vld_q;

endmodule

// File: tb/tb_clock_div_monitor.sv
// Directed bench for clock_div_monitor at default parameters; honours DIV_MON_STICKY_EN.
module tb_clock_div_monitor;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        div_i = 1'b0;
  logic        clr_i = 1'b0;
  logic        locked_o, fault_o, meas_vld_o;
  logic [1:0]  fault_code_o;
  logic [15:0] half_cnt_o;

  int checks = 0;
  int errors = 0;

  logic        ev_seen;
  logic [15:0] ev_m;
  int          ev_at;

  clock_div_monitor dut (
    .clk          (clk),
    .rstn         (rstn),
    .div_i        (div_i),
    .clr_i        (clr_i),
    .locked_o     (locked_o),
    .fault_o      (fault_o),
    .fault_code_o (fault_code_o),
    .half_cnt_o   (half_cnt_o),
    .meas_vld_o   (meas_vld_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Toggle div_i so the gap since the previous toggle is n cycles, then catch its meas pulse.
  task automatic interval(input int n);
    ev_seen = 1'b0;
    ev_m    = '0;
    ev_at   = -1;
    repeat (n - 4) @(posedge clk);
    #1 div_i = ~div_i;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (meas_vld_o && !ev_seen) begin
        ev_seen = 1'b1;
        ev_m    = half_cnt_o;
        ev_at   = i;
      end
    end
  endtask

  task automatic pulse_clr();
    clr_i = 1'b1;
    @(posedge clk);
    #1 clr_i = 1'b0;
  endtask

  task automatic apply_reset();
    rstn  = 1'b0;
    div_i = 1'b0;
    clr_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic relock();
    for (int e = 1; e <= 5; e++) begin
      interval(1040);
      if (e == 4) begin
        checks++;
        if (locked_o !== 1'b0) begin
          errors++; $display("FAIL relock_ev4: locked_o=%b want 0", locked_o);
        end
      end
    end
    checks++;
    if (locked_o !== 1'b1 || fault_o !== 1'b0) begin
      errors++; $display("FAIL relock_ev5: locked=%b fault=%b want 1 0", locked_o, fault_o);
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({locked_o, fault_o, fault_code_o, half_cnt_o, meas_vld_o} !== 21'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b/%b/%b/%0d/%b want all 0",
               locked_o, fault_o, fault_code_o, half_cnt_o, meas_vld_o);
    end
    apply_reset();
  endtask

  task automatic test_lock();
    for (int e = 1; e <= 6; e++) begin
      interval(1040);
      if (e >= 2) begin
        checks++;
        if (!ev_seen || ev_m !== 16'd1040) begin
          errors++; $display("FAIL lock_meas%0d: seen=%b m=%0d want 1 1040", e, ev_seen, ev_m);
        end
      end
      if (e == 2) begin
        checks++;
        if (ev_at !== 3) begin
          errors++; $display("FAIL event_latency: pulse at k+%0d want k+3", ev_at);
        end
      end
      checks++;
      if (locked_o !== (e >= 5)) begin
        errors++; $display("FAIL lock_ev%0d: locked_o=%b want %b", e, locked_o, e >= 5);
      end
    end
  endtask

  task automatic test_short();
    interval(1030);
    checks++;
    if (fault_o !== 1'b1 || fault_code_o !== 2'b01 || locked_o !== 1'b0) begin
      errors++;
      $display("FAIL short_fault: fault=%b code=%b locked=%b want 1 01 0",
               fault_o, fault_code_o, locked_o);
    end
`ifdef DIV_MON_STICKY_EN
    interval(1040);
    checks++;
    if (fault_o !== 1'b1 || fault_code_o !== 2'b01) begin
      errors++; $display("FAIL short_sticky: fault=%b code=%b want 1 01", fault_o, fault_code_o);
    end
    pulse_clr();
    checks++;
    if (fault_o !== 1'b0 || fault_code_o !== 2'b00 || locked_o !== 1'b0) begin
      errors++; $display("FAIL short_clr: fault=%b code=%b want 0 00", fault_o, fault_code_o);
    end
`else
    pulse_clr();
    checks++;
    if (fault_o !== 1'b1 || fault_code_o !== 2'b00) begin
      errors++; $display("FAIL short_clr: fault=%b code=%b want 1 00", fault_o, fault_code_o);
    end
`endif
    relock();
  endtask

  task automatic test_long();
    interval(1050);
    checks++;
    if (fault_o !== 1'b1 || fault_code_o !== 2'b10) begin
      errors++; $display("FAIL long_fault: fault=%b code=%b want 1 10", fault_o, fault_code_o);
    end
`ifdef DIV_MON_STICKY_EN
    pulse_clr();
    relock();
`else
    interval(1040);
    checks++;
    if (fault_o !== 1'b0 || fault_code_o !== 2'b10 || locked_o !== 1'b0) begin
      errors++;
      $display("FAIL long_recover: fault=%b code=%b locked=%b want 0 10 0",
               fault_o, fault_code_o, locked_o);
    end
    for (int e = 1; e <= 4; e++) begin
      interval(1040);
      checks++;
      if (locked_o !== (e == 4)) begin
        errors++; $display("FAIL long_relock%0d: locked_o=%b want %b", e, locked_o, e == 4);
      end
    end
`endif
  endtask

  task automatic test_stuck();
    repeat (2079) @(posedge clk);
    #1;
    checks++;
    if (fault_o !== 1'b0 || locked_o !== 1'b1) begin
      errors++; $display("FAIL stuck_early: fault=%b locked=%b want 0 1", fault_o, locked_o);
    end
    @(posedge clk);
    #1;
    checks++;
    if (fault_o !== 1'b1 || fault_code_o !== 2'b11 || locked_o !== 1'b0) begin
      errors++;
      $display("FAIL stuck_fault: fault=%b code=%b locked=%b want 1 11 0",
               fault_o, fault_code_o, locked_o);
    end
`ifdef DIV_MON_STICKY_EN
    pulse_clr();
`endif
    relock();
  endtask

  task automatic test_acq_reject();
    int seq [7] = '{1040, 1040, 1100, 1040, 1040, 1040, 1040};
    apply_reset();
    interval(1040);
    for (int i = 0; i < 7; i++) begin
      interval(seq[i]);
      checks++;
      if (fault_o !== 1'b0 || locked_o !== (i == 6)) begin
        errors++;
        $display("FAIL acq_seq%0d: fault=%b locked=%b want 0 %b", i, fault_o, locked_o, i == 6);
      end
    end
  endtask

  task automatic test_reset_mid();
    repeat (500) @(posedge clk);
    #3;
    rstn  = 1'b0;
    div_i = 1'b0;
    #1;
    checks++;
    if ({locked_o, fault_o, fault_code_o, half_cnt_o, meas_vld_o} !== 21'd0) begin
      errors++;
      $display("FAIL reset_mid: got %b/%b/%b/%0d/%b want all 0",
               locked_o, fault_o, fault_code_o, half_cnt_o, meas_vld_o);
    end
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    relock();
  endtask

  initial begin
    test_reset();
    test_lock();
    test_short();
    test_long();
    test_stuck();
    test_acq_reject();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_div_monitor.md
# clock_div_monitor

Checks the divided clock produced by the clock divider against the OSCH system clock that drives it. Measures every half-period of the divided output in system-clock cycles and declares lock after a run of in-tolerance intervals. Flags short, long, or stuck intervals to the dispense controller so it can inhibit motor timing when the timebase is bad.

## Interface
Parameters:
- `EXP_HALF`, 1040: expected half-period of `div_i` in `clk` cycles (2.08 MHz / 1 kHz / 2).
- `TOL`, 8: allowed deviation in cycles, ± around `EXP_HALF`.
- `LOCK_N`, 4: consecutive in-window intervals required for lock; valid range 1..15.
- `CNT_W`, 16: width of the interval counter; must satisfy 2·`EXP_HALF` < 2^`CNT_W`.

Ports:
- `clk` in 1: system clock from the OSCH oscillator.
- `rstn` in 1: asynchronous, active-low reset.
- `div_i` in 1: divided clock under test; treated as asynchronous.
- `clr_i` in 1: clear fault. Single-cycle pulse or level.
- `locked_o` out 1: high while in LOCKED.
- `fault_o` out 1: high while in FAULT.
- `fault_code_o` out 2: last fault cause. 00 none, 01 short, 10 long, 11 stuck.
- `half_cnt_o` out `CNT_W`: last measured interval.
- `meas_vld_o` out 1: one-cycle pulse when `half_cnt_o` updates.

## Operation
- **Input sync:** `div_i` passes through a 2-flop synchronizer, then a third flop for edge detection. Either edge counts as an event.
- **Counter:** `cnt` increments every cycle and saturates at all-ones. On an event:
  - m = `cnt`+1 is captured into `half_cnt_o`;
  - `meas_vld_o` pulses;
  - `cnt` is set to 0.
- **Window:** an interval is in-window iff `EXP_HALF`−`TOL` ≤ m ≤ `EXP_HALF`+`TOL`. It is short if below the window and long if above it.
- **Stuck:** the stuck condition is `cnt` == 2·`EXP_HALF`−1 with no event in that cycle.
- **States:** IDLE, ACQ, LOCKED, FAULT.
  - IDLE: the first event goes to ACQ. The counter runs, but this first interval is captured and not classified. Stuck is ignored.
  - ACQ, on an event:
    - in-window: `good` increments; when `good` reaches `LOCK_N`, go to LOCKED;
    - out-of-window: `good` is set to 0 and the state stays ACQ. No fault is raised before lock.
  - ACQ, on stuck: go to IDLE.
  - LOCKED: a short, long, or stuck condition goes to FAULT and loads `fault_code_o` with 01, 10, or 11.
  - FAULT, recovery:
    - without the macro: the next event goes to ACQ with `good`=0;
    - with the macro: see Configuration.
- `clr_i` clears `fault_code_o` to 00. If a fault is detected in the same cycle, the fault wins.
- In every state, `good` is cleared on entry to IDLE or FAULT.

## Timing
- **Reset values:** all outputs 0, `cnt`=0, `good`=0, state IDLE, synchronizer flops 0.
- **Event latency:** `div_i` is first sampled at its new level on clk edge k. `meas_vld_o`, `half_cnt_o`, state, and flags all update on edge k+3.
- **Stuck latency:** FAULT and code 11 are registered on the edge after `cnt` reaches 2·`EXP_HALF`−1.
- A perfect divider at half-period H produces m = H exactly. Sync jitter is ±1 cycle, which is covered by `TOL`.
- **Mid-operation reset:** asserting `rstn` returns everything to reset values immediately, with no clock needed. After release, the block restarts in IDLE.
- **Saturation:** at all-ones, `cnt` holds. A later event captures m = all-ones, which is classified as long.

## Configuration
- `DIV_MON_STICKY_EN` defined:
  - FAULT is latched and ignores events;
  - `clr_i` moves FAULT to IDLE;
  - `fault_o` stays high until then.
- `DIV_MON_STICKY_EN` undefined:
  - FAULT auto-recovers on the next event, as described in Operation;
  - `clr_i` only clears `fault_code_o`.

## Test plan
All scenarios use default parameters.
1. Reset, then a 1040-cycle half-period for 6 intervals → `half_cnt_o`=1040 on each `meas_vld_o`; `locked_o` rises on the 5th event (first event + 4 good).
2. Locked, then one interval of 1030 cycles → `fault_o`=1, `fault_code_o`=01. Sticky build: a 1040 interval keeps FAULT; `clr_i` → IDLE, code 00.
3. Locked, then one interval of 1050 cycles → code 10. Non-sticky build: next event → ACQ, `fault_o`=0, code holds at 10; 4 more good intervals → LOCKED.
4. Locked, then `div_i` held constant → code 11 asserted on the edge after `cnt` reaches 2079; `locked_o`=0.
5. In ACQ, intervals 1040, 1040, 1100, 1040×4 → no fault; lock only after the final 4 in-window intervals.
6. `rstn` pulsed low mid-interval while locked → all outputs 0 asynchronously; relock requires 5 events.
